// File: rtl/jtag_dtm_tap_if.sv
// rtl/jtag_dtm_tap_if.sv - DMI request/response handshake between the DTM and the debug module
interface jtag_dtm_tap_if #(
    parameter int ABITS = 7
) ();
    logic             req_valid;
    logic             req_ready;
    logic [ABITS-1:0] req_addr;
    logic [31:0]      req_data;
    logic [1:0]       req_op;
    logic             resp_valid;
    logic [31:0]      resp_data;
    logic [1:0]       resp_op;

    modport master (
        output req_valid, req_addr, req_data, req_op,
        input  req_ready, resp_valid, resp_data, resp_op
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_op,
        output req_ready, resp_valid, resp_data, resp_op
    );
endinterface

// File: rtl/jtag_dtm_tap.sv
// rtl/jtag_dtm_tap.sv - IEEE 1149.1 TAP with RISC-V 0.13 debug transport module (IDCODE/DTMCS/DMI/BYPASS)
module jtag_dtm_tap #(
    parameter logic [31:0] IDCODE = 32'h1000_1CFF,
    parameter int          ABITS  = 7
) (
    input  logic           tck_i,
    input  logic           trst_i,
    input  logic           tms_i,
    input  logic           tdi_i,
    output logic           tdo_o,
    output logic           tdo_en_o,
    jtag_dtm_tap_if.master dmi
);
    localparam int DW = ABITS + 34;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_e;

    tap_state_e       state_q;
    logic [4:0]       ir_q, ir_sh_q;
    logic [DW-1:0]    dr_q, dr_capture, dr_shifted;
    dr_sel_e          dr_sel;
    logic             tdo_q, tdo_en_q;

    logic             busy_q, busy_d;
    logic [1:0]       sticky_q, sticky_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic [ABITS-1:0] last_addr_q, last_addr_d;
    logic             req_valid_q, req_valid_d;
    logic [ABITS-1:0] req_addr_q, req_addr_d;
    logic [31:0]      req_data_q, req_data_d;
    logic [1:0]       req_op_q, req_op_d;

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            state_q <= TLR;
        end else begin
            case (state_q)
                TLR:     state_q <= tms_i ? TLR    : RTI;
                RTI:     state_q <= tms_i ? SEL_DR : RTI;
                SEL_DR:  state_q <= tms_i ? SEL_IR : CAP_DR;
                CAP_DR:  state_q <= tms_i ? EX1_DR : SH_DR;
                SH_DR:   state_q <= tms_i ? EX1_DR : SH_DR;
                EX1_DR:  state_q <= tms_i ? UPD_DR : PA_DR;
                PA_DR:   state_q <= tms_i ? EX2_DR : PA_DR;
                EX2_DR:  state_q <= tms_i ? UPD_DR : SH_DR;
                UPD_DR:  state_q <= tms_i ? SEL_DR : RTI;
                SEL_IR:  state_q <= tms_i ? TLR    : CAP_IR;
                CAP_IR:  state_q <= tms_i ? EX1_IR : SH_IR;
                SH_IR:   state_q <= tms_i ? EX1_IR : SH_IR;
                EX1_IR:  state_q <= tms_i ? UPD_IR : PA_IR;
                PA_IR:   state_q <= tms_i ? EX2_IR : PA_IR;
                EX2_IR:  state_q <= tms_i ? UPD_IR : SH_IR;
                default: state_q <= tms_i ? SEL_DR : RTI;
            endcase
        end
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            ir_q    <= 5'h01;
            ir_sh_q <= 5'h00;
        end else begin
            case (state_q)
                TLR:     ir_q    <= 5'h01;
                CAP_IR:  ir_sh_q <= 5'b00001;
                SH_IR:   ir_sh_q <= {tdi_i, ir_sh_q[4:1]};
                UPD_IR:  ir_q    <= ir_sh_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (ir_q)
            5'h01:   dr_sel = DR_IDCODE;
            5'h10:   dr_sel = DR_DTMCS;
            5'h11:   dr_sel = DR_DMI;
            default: dr_sel = DR_BYPASS;
        endcase
    end

    // Each DR shifts right with TDI entering at its own MSB; bits above the selected length stay zero.
    always_comb begin
        dr_capture = '0;
        dr_shifted = '0;
        case (dr_sel)
            DR_IDCODE: begin
                dr_capture[31:0] = IDCODE;
                dr_shifted[31:0] = {tdi_i, dr_q[31:1]};
            end
            DR_DTMCS: begin
                dr_capture[31:0] = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, sticky_q, 6'(ABITS), 4'd1};
                dr_shifted[31:0] = {tdi_i, dr_q[31:1]};
            end
            DR_DMI: begin
                dr_capture = {last_addr_q, resp_data_q, (busy_q ? 2'd3 : sticky_q)};
                dr_shifted = {tdi_i, dr_q[DW-1:1]};
            end
            default: begin
                dr_shifted[0] = tdi_i;
            end
        endcase
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            dr_q <= '0;
        end else if (state_q == CAP_DR) begin
            dr_q <= dr_capture;
        end else if (state_q == SH_DR) begin
            dr_q <= dr_shifted;
        end
    end

    // Response is retired before the scan update so an update on the same edge sees busy cleared.
    always_comb begin
        busy_d      = busy_q;
        sticky_d    = sticky_q;
        resp_data_d = resp_data_q;
        last_addr_d = last_addr_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_op_d    = req_op_q;

        if (req_valid_q && dmi.req_ready) begin
            req_valid_d = 1'b0;
        end
        if (dmi.resp_valid && busy_q) begin
            busy_d = 1'b0;
            if (req_op_q == 2'd1) begin
                resp_data_d = dmi.resp_data;
            end
            if (dmi.resp_op != 2'd0 && sticky_d == 2'd0) begin
                sticky_d = 2'd2;
            end
        end

        if (state_q == UPD_DR && dr_sel == DR_DMI) begin
            if (busy_d) begin
                if (sticky_d == 2'd0) begin
                    sticky_d = 2'd3;
                end
            end else if (sticky_d == 2'd0 && (dr_q[1:0] == 2'd1 || dr_q[1:0] == 2'd2)) begin
                req_addr_d  = dr_q[DW-1:34];
                req_data_d  = dr_q[33:2];
                req_op_d    = dr_q[1:0];
                last_addr_d = dr_q[DW-1:34];
                busy_d      = 1'b1;
                req_valid_d = 1'b1;
            end
        end

        if (state_q == UPD_DR && dr_sel == DR_DTMCS) begin
            if (dr_q[17]) begin
                sticky_d    = 2'd0;
                busy_d      = 1'b0;
                req_valid_d = 1'b0;
            end else if (dr_q[16]) begin
                sticky_d = 2'd0;
            end
        end
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            busy_q      <= 1'b0;
            sticky_q    <= 2'd0;
            resp_data_q <= '0;
            last_addr_q <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_op_q    <= 2'd0;
        end else begin
            busy_q      <= busy_d;
            sticky_q    <= sticky_d;
            resp_data_q <= resp_data_d;
            last_addr_q <= last_addr_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_op_q    <= req_op_d;
        end
    end

    always_ff @(negedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else if (state_q == SH_IR) begin
            tdo_q    <= ir_sh_q[0];
            tdo_en_q <= 1'b1;
        end else if (state_q == SH_DR) begin
            tdo_q    <= dr_q[0];
            tdo_en_q <= 1'b1;
        end else begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end
    end

    assign tdo_o         = tdo_q;
    assign tdo_en_o      = tdo_en_q;
    assign dmi.req_valid = req_valid_q;
    assign dmi.req_addr  = req_addr_q;
    assign dmi.req_data  = req_data_q;
    assign dmi.req_op    = req_op_q;
endmodule
